// File: rtl/display_bcd_driver_if.sv
// Display value interface: producer presents a value with a load request,
// the driver returns conversion status and the segment pattern.
interface display_bcd_driver_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic [WIDTH-1:0]    value_in;
  logic                load;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [7*DIGITS-1:0] hex_out;

  modport master (
    output value_in, load,
    input  busy, done, overflow, hex_out
  );

  modport slave (
    input  value_in, load,
    output busy, done, overflow, hex_out
  );
endinterface

// File: rtl/display_bcd_driver.sv
// Binary-to-decimal seven-segment driver: sequential double-dabble, one shift
// per clock, with a one-deep pending request and leading-zero blanking.
module display_bcd_driver #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 8,
  parameter int BLANK_LZ = 1
) (
  input logic clk,
  input logic reset,
  display_bcd_driver_if.slave bus
);

  localparam int BCD_D = 10;
  localparam int BCD_W = 4 * BCD_D;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [WIDTH-1:0]    pend_q;
  logic                pend_vld_q;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q, done_q, ovf_q, ovf_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                seen;
  logic [3:0]          nib;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Nibbles never exceed 9 here, so the 4-bit add cannot carry out.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       n;
    r = b;
    for (int i = 0; i < BCD_D; i++) begin
      n = b[4*i +: 4];
      r[4*i +: 4] = (n >= 4'd5) ? n + 4'd3 : n;
    end
    return r;
  endfunction

  always_comb begin
    logic [BCD_W-1:0] adj;
    adj   = add3(bcd_q);
    bcd_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
    bin_d = {bin_q[WIDTH-2:0], 1'b0};
  end

  // Digits above the display width only matter as an overflow indication.
  always_comb begin
    ovf_d = 1'b0;
    hex_d = '1;
    seen  = 1'b0;
    nib   = '0;
    for (int i = DIGITS; i < BCD_D; i++)
      if (bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = bcd_q[4*k +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (ovf_d)
        hex_d[7*k +: 7] = 7'b0111111;
      else if (BLANK_LZ != 0 && !seen && k != 0)
        hex_d[7*k +: 7] = 7'b1111111;
      else
        hex_d[7*k +: 7] = seg7(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= '1;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            bin_q   <= bus.value_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= UPDATE;
          if (bus.load) begin
            pend_q     <= bus.value_in;
            pend_vld_q <= 1'b1;
          end
        end
        UPDATE: begin
          hex_q  <= hex_d;
          ovf_q  <= ovf_d;
          done_q <= 1'b1;
          bcd_q  <= '0;
          cnt_q  <= '0;
          // A load arriving now is newer than any pending value, so it wins.
          if (bus.load) begin
            bin_q      <= bus.value_in;
            pend_vld_q <= 1'b0;
            state_q    <= CONVERT;
          end else if (pend_vld_q) begin
            bin_q      <= pend_q;
            pend_vld_q <= 1'b0;
            state_q    <= CONVERT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hex_out  = hex_q;

endmodule

// File: tb/tb_display_bcd_driver.sv
// Scoreboarded bench for display_bcd_driver: directed loads push expected
// display results, a done-triggered monitor pops and compares them.
module tb_display_bcd_driver;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct packed {
    logic [7*DIGITS-1:0] hex;
    logic                ovf;
    logic [31:0]         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  display_bcd_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  display_bcd_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hex_out",   {8'd0, bus.hex_out}, {8'd0, e.hex});
        check("overflow",  {63'd0, bus.overflow}, {63'd0, e.ovf});
        check("done_cycle", 64'(cyc), {32'd0, e.cyc});
      end
    end
    prev_done <= bus.done;
  end

  task automatic do_load(input logic [WIDTH-1:0] v, output int n);
    bus.value_in = v;
    bus.load     = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    n = cyc;
  endtask

  task automatic expect_result(input logic [7*DIGITS-1:0] hex, input logic ovf, input int at);
    exp_t e;
    e.hex = hex;
    e.ovf = ovf;
    e.cyc = 32'(at);
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n, n0;
    logic ok;
    bus.value_in = '0;
    bus.load     = 1'b0;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hex",  {8'd0, bus.hex_out}, {8'd0, {DIGITS{BL}}});
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_ovf",  {63'd0, bus.overflow}, 64'd0);
    @(posedge clk); #1;

    // Zero shows a single 0 digit
    do_load(32'd0, n);
    check("busy_after_load", {63'd0, bus.busy}, 64'd1);
    expect_result({{7{BL}}, S0}, 1'b0, n + 33);
    drain();
    check("idle_after_done", {63'd0, bus.busy}, 64'd0);

    do_load(32'd12345678, n);
    expect_result({S1, S2, S3, S4, S5, S6, S7, S8}, 1'b0, n + 33);
    drain();

    do_load(32'd100000000, n);
    expect_result({DIGITS{DS}}, 1'b1, n + 33);
    drain();
    do_load(32'd99999999, n);
    expect_result({DIGITS{S9}}, 1'b0, n + 33);
    drain();
    do_load(32'hFFFF_FFFF, n);
    expect_result({DIGITS{DS}}, 1'b1, n + 33);
    drain();

    // Back-to-back loads: 9 is overwritten by 7 while 42 converts
    @(posedge clk); #1;
    do_load(32'd42, n0);
    expect_result({{6{BL}}, S4, S2}, 1'b0, n0 + 33);
    repeat (4) @(posedge clk);
    #1;
    do_load(32'd9, n);
    check("busy_pend1", {63'd0, bus.busy}, 64'd1);
    check("load2_cycle", 64'(n), 64'(n0 + 5));
    repeat (4) @(posedge clk);
    #1;
    do_load(32'd7, n);
    check("load3_cycle", 64'(n), 64'(n0 + 10));
    expect_result({{7{BL}}, S7}, 1'b0, n0 + 66);
    ok = 1'b1;
    @(negedge clk);
    while (cyc < n0 + 66) begin
      if (!bus.busy) ok = 1'b0;
      @(negedge clk);
    end
    check("busy_continuous", {63'd0, ok}, 64'd1);
    check("busy_drop", {63'd0, bus.busy}, 64'd0);
    drain();

    // Reset mid-conversion abandons the result
    do_load(32'd42, n);
    expect_result({{6{BL}}, S4, S2}, 1'b0, n + 33);
    drain();
    do_load(32'd5, n);
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_hex",  {8'd0, bus.hex_out}, {8'd0, {DIGITS{BL}}});
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_ovf",  {63'd0, bus.overflow}, 64'd0);
    repeat (40) @(negedge clk);
    #1;
    do_load(32'd3, n);
    expect_result({{7{BL}}, S3}, 1'b0, n + 33);
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_bcd_driver.md
Name: display_bcd_driver

Overview:
- Downstream consumer of the data memory's 32-bit display output register.
- Converts an unsigned binary value to decimal with a sequential double-dabble engine: one shift per clock.
- Drives DIGITS active-low seven-segment digits, as on the board HEX displays.
- Sits between the memory stage's display output and the top-level HEX pins.

Parameters:
- WIDTH, 32, bit width of value_in and number of conversion iterations.
- DIGITS, 8, number of seven-segment digits driven; the BCD engine holds 10 digits internally.
- BLANK_LZ, 1, when 1 leading zeros are blanked (digit 0 always shown).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value_in  input  WIDTH  unsigned value to display; sampled only when load is accepted.
- load  input  1  request to convert value_in.
- busy  output  1  high while a conversion is in progress or pending.
- done  output  1  one-cycle pulse when hex_out/overflow are updated.
- overflow  output  1  value exceeded 10^DIGITS-1; held until the next update.
- hex_out  output  7*DIGITS  segments, digit k at [7k+6:7k], bit order gfedcba, active-low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled high on any edge, in any state, including mid-conversion):
  - state IDLE; pending flag cleared; busy=0, done=0, overflow=0.
  - hex_out all ones (every digit blank).
  - A conversion in flight is abandoned; no done pulse.
- States:
  - IDLE: load=1 at edge N captures value_in into the shift register, clears the 40-bit BCD register and the iteration counter, and goes to CONVERT. busy=1 from edge N.
  - CONVERT: each edge, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After WIDTH iterations (edges N+1..N+WIDTH) go to UPDATE.
  - UPDATE: at edge N+WIDTH+1:
    - latch hex_out and overflow; done=1 for exactly this one cycle.
    - If the pending flag is set: load the pending value, clear the flag, go to CONVERT (busy stays 1).
    - Otherwise go to IDLE; busy=0.
- Latency: load accepted at edge N -> done visible after edge N+33 (WIDTH=32).
- load while busy (CONVERT or UPDATE):
  - value_in is stored in a one-deep pending register and the pending flag is set.
  - A later load before service overwrites it (last value wins).
  - The current conversion is never disturbed.
- load in UPDATE is treated as pending; it is serviced immediately in the same edge.
- Overflow: any nonzero BCD digit at index >= DIGITS.
  - overflow=1; every digit shows dash 0111111.
- Digit encoding (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking (BLANK_LZ=1): digit k blanked if it and all higher digits are zero, except digit 0. BLANK_LZ=0 shows all zeros.
- hex_out/overflow change only at UPDATE or reset; outputs are stable during conversion (previous result held).
- Arithmetic: nibble add-3 in 4 bits with no carry out; the 10-digit BCD register never overflows for WIDTH=32 (max 4294967295).

Test Plan:
1. Assert reset 2 cycles -> hex_out all ones, busy=0, done=0, overflow=0.
2. load with value_in=0 at edge N -> busy=1 after N; done pulse after N+33; digit0=1000000, digits1-7=1111111, overflow=0.
3. load value_in=12345678 -> after 33 cycles digit7..digit0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000; overflow=0.
4. load value_in=100000000 -> overflow=1, all eight digits 0111111. Then load 99999999 -> overflow=0, all digits 0010000.
5. load 42 at N, load 9 at N+5, then load 7 at N+10 -> first done at N+33 shows "42". Second done at N+66 shows "7" (9 discarded). busy=1 continuously from N to N+66, then 0.
6. load 42 and let it complete; then load 5 and assert reset at conversion cycle 15 -> hex_out all ones, busy=0, no done pulse. A subsequent load 3 completes normally after 33 cycles.
